// File: rtl/serdesphy_ana_debug_capture.sv
// serdesphy_ana_debug_capture
//   Digitizes the 1-bit analog debug comparator back into bytes. The input
//   is synchronized, sampled LSB first once every div+1 clocks, and each
//   assembled byte is pushed into a small FWFT FIFO with a valid/ready
//   output side.
//
// Build option:
//   SERDESPHY_DBG_CAP_MAJORITY_EN - captured bit is the majority of the
//   synchronized input over the last three cycles (glitch rejection,
//   meaningful for div >= 2). Undefined: captured bit is sync_in itself.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   enable        block enable; low during a capture aborts it
//   start         one-cycle request to capture a byte
//   div           bit period in clk cycles minus 1 (stable while busy)
//   dbg_ana_in    asynchronous comparator input
//   data_out      FIFO head byte
//   data_valid    FIFO not empty
//   data_ready    consumer accepts data_out
//   busy          capture in progress
//   overflow      sticky: a byte was dropped on a full FIFO
//   clear_ovf     clears overflow (a same-cycle drop wins)
module serdesphy_ana_debug_capture #(
  parameter int DIV_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic             dbg_ana_in,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             clear_ovf
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CAPTURE} state_t;

  // input synchronizer
  logic sync1_q, sync_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync1_q <= dbg_ana_in;
      sync_in <= sync1_q;
    end
  end

  // bit value taken on a sample edge
  logic samp_bit;
`ifdef SERDESPHY_DBG_CAP_MAJORITY_EN
  // window is the current sync_in plus its two previous values
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b00;
    else        hist_q <= {hist_q[0], sync_in};
  end
  assign samp_bit = (sync_in & hist_q[0]) | (sync_in & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp_bit = sync_in;
`endif

  // capture FSM
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [6:0]       shift_q, shift_d;
  logic             push;
  logic [7:0]       push_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 7'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_byte = {samp_bit, shift_q};
    case (state_q)
      IDLE: begin
        if (start && enable) begin
          state_d   = CAPTURE;
          cnt_d     = div;
          bit_idx_d = 3'd0;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          // partial byte is simply abandoned
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (bit_idx_q == 3'd7) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            shift_d[bit_idx_q] = samp_bit;
            cnt_d              = div;
            bit_idx_d          = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CAPTURE);

  // FWFT FIFO; extra pointer MSB distinguishes full from empty
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, wr_en, drop;
  logic        ovf_q, ovf_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && data_ready;
  // a pop on the same edge frees the slot the push needs
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_byte;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      ovf_q <= ovf_d;
    end
  end

  assign data_out   = mem_q[rd_ptr_q[AW-1:0]];
  assign data_valid = !empty;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_serdesphy_ana_debug_capture.sv
module tb_serdesphy_ana_debug_capture;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, start = 1'b0;
  logic       dbg = 1'b0, data_ready = 1'b0, clear_ovf = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] data_out;
  logic       data_valid, busy, overflow;

  serdesphy_ana_debug_capture #(.DIV_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .div(div),
    .dbg_ana_in(dbg), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Time-based: a capture is a count of elapsed clocks since start; bit k is
  // taken when the count hits (k+1)(div+1). The input seen on an edge is the
  // raw pin value two edges earlier.
  byte unsigned mq[$];
  bit           m_busy, m_ovf;
  int           m_t, m_d, m_k;
  logic [7:0]   m_bits;
  bit           h1, h2, h3, h4;
  bit           m_pop, m_push, m_drop, m_samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_ovf = 0; m_t = 0; m_bits = 0;
      h1 = 0; h2 = 0; h3 = 0; h4 = 0;
    end else begin
      m_pop  = (mq.size() > 0) && data_ready;
      m_push = 0;
`ifdef SERDESPHY_DBG_CAP_MAJORITY_EN
      m_samp = (int'(h2) + int'(h3) + int'(h4)) >= 2;
`else
      m_samp = h2;
`endif
      if (m_busy) begin
        if (!enable) m_busy = 0;
        else begin
          m_t++;
          if (m_t % (m_d + 1) == 0) begin
            m_k = m_t / (m_d + 1) - 1;
            m_bits[m_k] = m_samp;
            if (m_k == 7) begin m_push = 1; m_busy = 0; end
          end
        end
      end else if (start && enable) begin
        m_busy = 1; m_t = 0; m_d = int'(div);
      end
      m_drop = m_push && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_drop) mq.push_back(m_bits);
      if (clear_ovf) m_ovf = 0;
      if (m_drop) m_ovf = 1;
      h4 = h3; h3 = h2; h2 = h1; h1 = dbg;
    end
  end

  // ---------------- per-cycle compare ----------------
  byte unsigned got[$];
  int           busy_cnt = 0;

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("data_valid", int'(data_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk("data_out", int'(data_out), int'(mq[0]));
    if (data_valid && data_ready) got.push_back(data_out);
    if (busy) busy_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // mode 0: full capture, 1: drop enable after stop_k bits, 2: reset after stop_k bits
  task automatic cap(input logic [7:0] b, input int d, input int mode, input int stop_k,
                     input int glitch_c, input bit rdy_push);
    int L, k;
    L   = 8 * (d + 1);
    div = d[7:0];
    dbg = b[0];
    step();
    start = 1'b1;
    for (int c = 0; c <= L; c++) begin
      k = (c + 1) / (d + 1);
      if (k > 7) k = 7;
      dbg = b[k] | (c == glitch_c);
      if (c == L && rdy_push) data_ready = 1'b1;
      step();
      start = 1'b0;
      if (c == L && rdy_push) data_ready = 1'b0;
      if (mode != 0 && c == stop_k * (d + 1)) begin
        if (mode == 1) begin
          enable = 1'b0;
          step();
          chk("abort_busy", int'(busy), 0);
          chk("abort_valid", int'(data_valid), 0);
          enable = 1'b1;
        end else begin
          rst_n = 1'b0;
          #1;
          chk("rst_busy", int'(busy), 0);
          chk("rst_valid", int'(data_valid), 0);
          chk("rst_data", int'(data_out), 0);
          chk("rst_ovf", int'(overflow), 0);
          @(posedge clk); #1;
          rst_n = 1'b1;
          step();
        end
        return;
      end
    end
  endtask

  task automatic drain(input int n);
    data_ready = 1'b1;
    repeat (n) step();
    data_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("reset_data", int'(data_out), 0);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    step();

    // start with enable low is ignored
    start = 1'b1; step(); start = 1'b0; step();
    chk("start_dis_busy", int'(busy), 0);
    enable = 1'b1;

    // basic capture
    data_ready = 1'b1;
    got.delete(); busy_cnt = 0;
    cap(8'hA5, 3, 0, 0, -99, 0);
    step(); step();
    chk("basic_busy_cycles", busy_cnt, 32);
    chk("basic_count", got.size(), 1);
    if (got.size() == 1) chk("basic_byte", int'(got[0]), 8'hA5);
    data_ready = 1'b0;

    // overflow: five bytes into a four-deep FIFO
    got.delete();
    cap(8'h11, 2, 0, 0, -99, 0);
    cap(8'h22, 2, 0, 0, -99, 0);
    cap(8'h33, 2, 0, 0, -99, 0);
    cap(8'h44, 2, 0, 0, -99, 0);
    chk("ovf_before", int'(overflow), 0);
    cap(8'h55, 2, 0, 0, -99, 0);
    step();
    chk("ovf_set", int'(overflow), 1);
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0; step();
    chk("ovf_cleared", int'(overflow), 0);
    drain(6);
    chk("ovf_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("ovf_order", int'(got[i]), 8'h11 * (i + 1));

    // abort after three bits, then a clean capture
    got.delete();
    cap(8'hFF, 3, 1, 3, -99, 0);
    repeat (3) step();
    chk("abort_no_push", int'(data_valid), 0);
    cap(8'hC3, 3, 0, 0, -99, 0);
    drain(2);
    chk("after_abort_count", got.size(), 1);
    if (got.size() == 1) chk("after_abort_byte", int'(got[0]), 8'hC3);

    // full FIFO with push and pop on the same edge
    got.delete();
    cap(8'hA1, 2, 0, 0, -99, 0);
    cap(8'hB2, 2, 0, 0, -99, 0);
    cap(8'hC3, 2, 0, 0, -99, 0);
    cap(8'hD4, 2, 0, 0, -99, 0);
    cap(8'hE5, 2, 0, 0, -99, 1);
    step();
    chk("pp_ovf", int'(overflow), 0);
    chk("pp_popped", got.size(), 1);
    drain(4);
    chk("pp_empty", int'(data_valid), 0);
    chk("pp_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("pp_b1", int'(got[1]), 8'hB2);
      chk("pp_tail", int'(got[4]), 8'hE5);
    end

    // reset mid-capture with two bytes queued
    got.delete();
    cap(8'h5A, 2, 0, 0, -99, 0);
    cap(8'h3C, 2, 0, 0, -99, 0);
    chk("rst_pre_valid", int'(data_valid), 1);
    enable = 1'b1;
    cap(8'hFF, 3, 2, 4, -99, 0);
    step();
    chk("rst_empty", int'(data_valid), 0);
    chk("rst_nopop", got.size(), 0);
    cap(8'h69, 3, 0, 0, -99, 0);
    drain(2);
    if (got.size() == 1) chk("rst_after_byte", int'(got[0]), 8'h69);
    else chk("rst_after_count", got.size(), 1);

    // glitch on bit 2's sample edge
    got.delete();
    cap(8'h00, 3, 0, 0, 10, 0);
    drain(2);
`ifdef SERDESPHY_DBG_CAP_MAJORITY_EN
    if (got.size() == 1) chk("glitch_byte", int'(got[0]), 8'h00);
`else
    if (got.size() == 1) chk("glitch_byte", int'(got[0]), 8'h04);
`endif
    else chk("glitch_count", got.size(), 1);

    // div extremes
    got.delete();
    cap(8'h96, 255, 0, 0, -99, 0);
    cap(8'h3C, 0, 0, 0, -99, 0);
    drain(3);
    chk("div_count", got.size(), 2);
    if (got.size() >= 1) chk("div_max_byte", int'(got[0]), 8'h96);
`ifndef SERDESPHY_DBG_CAP_MAJORITY_EN
    if (got.size() >= 2) chk("div0_byte", int'(got[1]), 8'h3C);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
